rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (LU: multiply/divide, non-blocking load return). Pipeline writes always win. LU results queue in a small buffer with kill-on-overwrite. An optional starvation guard requests a one-cycle pipeline bubble to drain the buffer. The block sits between the writeback stage outputs and the register file write port.

## Interface
- DEPTH, 2: LU result buffer entries; power of two, ≥2
- STARVE_LIMIT, 4: consecutive denied cycles before StallReq fires (1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- PipeRegWrite  in  1  writeback-stage write request
- PipeRd  in  5  writeback destination
- PipeData  in  32  writeback data
- LuValid  in  1  LU result valid
- LuRd  in  5  LU destination
- LuData  in  32  LU data
- LuReady  out  1  buffer can accept; transfer when LuValid & LuReady
- StallReq  out  1  registered; pipeline must hold PipeRegWrite=0 in the same cycle
- RfWe  out  1  register-file write enable (registered)
- RfWaddr  out  5  register-file write address (registered)
- RfWdata  out  32  register-file write data (registered)
- BufCount  out  $clog2(DEPTH)+1  occupied buffer entries (live and killed)

## Operation
- Pipe request counts only when PipeRegWrite=1 and PipeRd≠0.
- Grant each cycle: pipe request if present. Otherwise, buffer head if the buffer is non-empty. Otherwise, idle.
- Buffer head pop: a live head drives the RF write. A killed head is popped silently with RfWe=0, and still counts as serviced.
- LU push when LuValid & LuReady. LuRd=0 is accepted and discarded (not pushed).
- LuReady = ~rst & (BufCount < DEPTH). No same-cycle pop-through. LU data always enters the buffer first.
- Ordering contract: LU results are older than any concurrent or later pipe write.
- On a granted pipe write to rd=r:
  - every buffered entry with rd=r is killed;
  - an LU result pushed in that same cycle with rd=r is stored as killed.
- Simultaneous push and pop: both take effect; BufCount is unchanged.
- Reset mid-operation: the buffer is flushed and pending LU results are lost. The LU is reset alongside.

## Timing
- Reset values: RfWe=0, RfWaddr=0, RfWdata=0, StallReq=0, BufCount=0, LuReady=0 while rst=1. LuReady=1 in the first cycle after rst falls.
- Pipe request at cycle n → RfWe/RfWaddr/RfWdata at n+1.
- LU push at n with an idle pipe → RF write at n+2 at the earliest.
- Throughput: one RF write per cycle. Sustained pipe traffic blocks LU drain (see Configuration).

## Configuration
- RF_ARB_STARVE_GUARD_EN defined:
  - a starvation counter increments each cycle the buffer is non-empty and the head is not popped;
  - it clears on any pop;
  - when it reaches STARVE_LIMIT, StallReq=1 for exactly the next cycle, and the head is popped in that cycle;
  - if the pipe writes despite StallReq, the pipe still wins and the counter holds at STARVE_LIMIT, so StallReq re-fires.
- Macro undefined: no counter, StallReq tied 0, and LU results wait indefinitely behind pipe traffic.

## Structure
- Shared package rv_core_pkg:
  - constants XLEN=32, REG_ADDR_W=5, ZERO_REG=5'd0;
  - typedef rf_wr_t {we, rd, data}.
- Sub-module wb_arb_fifo: circular buffer of DEPTH entries {live, rd, data}, with push, pop, and broadcast kill-by-rd ports; exposes head and count.
- Top level holds grant logic, output registers and the starvation counter.

## Test plan
- Reset: hold rst 2 cycles with LuValid=1 → all outputs 0 and LuReady=0. After release, LuReady=1 and BufCount=0.
- Pipe only: PipeRegWrite=1, PipeRd=1, PipeData=DEADBEEF → next cycle RfWe=1, RfWaddr=1, RfWdata=DEADBEEF. Then PipeRd=0 → RfWe=0.
- LU drain: idle pipe, push LuRd=2, LuData=CAFEBABE at n → RfWe=1, RfWaddr=2 at n+2, BufCount back to 0.
- Full/backpressure: DEPTH=2, pipe busy every cycle, push two LU results → LuReady=0 and a third LuValid is held. The pipe stops → RF writes in push order, and LuReady returns to 1.
- Kill: buffer holds rd=5 value 5555AAAA, then pipe writes rd=5 value 11111111 → RF writes 11111111 to x5 only. The killed entry pops with RfWe=0.
- Starvation (guard on, STARVE_LIMIT=4): one buffered entry, continuous pipe writes → StallReq=1 for one cycle after 4 denied cycles. The pipe drops PipeRegWrite → the LU entry is written and the counter clears.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core constants and the register-file write record used by the
// writeback arbiter and its LU result buffer.
package rv_core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

  // x0 is hardwired, so a write aimed at it is no write at all.
  function automatic logic writesReg(input logic we, input logic [REG_ADDR_W-1:0] rd);
    return we && (rd != ZERO_REG);
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular buffer of pending LU results. The entry's "we" bit is its live flag;
// a broadcast kill clears it on every entry whose destination matches.
module wb_arb_fifo
  import rv_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  rf_wr_t                pushEntry,
  input  logic                  pop,
  input  logic                  killEn,
  input  logic [REG_ADDR_W-1:0] killRd,
  output rf_wr_t                head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  rf_wr_t          mem [DEPTH];
  logic [PtrW-1:0] headPtr;
  logic [PtrW-1:0] tailPtr;

  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + PtrW'(1);
      if (pop)  headPtr <= headPtr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; count alone decides which slots hold entries.
  // A push into the tail slot is written after the kill loop so it takes precedence.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (killEn && (mem[i].rd == killRd)) mem[i].we <= 1'b0;
    end
    if (push) mem[tailPtr] <= pushEntry;
  end

  assign head = mem[headPtr];

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, LU results
// drain from a kill-on-overwrite buffer. Optional starvation guard: RF_ARB_STARVE_GUARD_EN.
module rf_write_arbiter
  import rv_core_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PipeRegWrite,
  input  logic [REG_ADDR_W-1:0]  PipeRd,
  input  logic [XLEN-1:0]        PipeData,
  input  logic                   LuValid,
  input  logic [REG_ADDR_W-1:0]  LuRd,
  input  logic [XLEN-1:0]        LuData,
  output logic                   LuReady,
  output logic                   StallReq,
  output logic                   RfWe,
  output logic [REG_ADDR_W-1:0]  RfWaddr,
  output logic [XLEN-1:0]        RfWdata,
  output logic [$clog2(DEPTH):0] BufCount
);

  localparam int CntW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15)
  begin : gBadParams
    $error("rf_write_arbiter: DEPTH must be a power of two >= 2, STARVE_LIMIT in 1..15");
  end

  logic   pipeReq;
  logic   bufNonEmpty;
  logic   popHead;
  logic   pushLu;
  rf_wr_t pushEntry;
  rf_wr_t head;

  assign pipeReq     = writesReg(PipeRegWrite, PipeRd);
  assign bufNonEmpty = (BufCount != '0);
  // Pop decisions use the registered count, so a fresh LU push is never popped through.
  assign popHead     = !pipeReq && bufNonEmpty;
  assign LuReady     = !rst && (BufCount < CntW'(DEPTH));
  assign pushLu      = LuValid && LuReady && (LuRd != ZERO_REG);

  // An LU result is older than a concurrent pipe write to the same rd.
  assign pushEntry = '{we:   !(pipeReq && (PipeRd == LuRd)),
                       rd:   LuRd,
                       data: LuData};

  wb_arb_fifo #(.DEPTH(DEPTH)) fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushLu),
    .pushEntry(pushEntry),
    .pop      (popHead),
    .killEn   (pipeReq),
    .killRd   (PipeRd),
    .head     (head),
    .count    (BufCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      RfWe    <= 1'b0;
      RfWaddr <= '0;
      RfWdata <= '0;
    end else if (pipeReq) begin
      RfWe    <= 1'b1;
      RfWaddr <= PipeRd;
      RfWdata <= PipeData;
    end else if (popHead) begin
      RfWe    <= head.we;
      RfWaddr <= head.rd;
      RfWdata <= head.data;
    end else begin
      RfWe    <= 1'b0;
    end
  end

`ifdef RF_ARB_STARVE_GUARD_EN
  logic [3:0] starveCnt;
  logic [3:0] starveNext;

  // NOTE: blocking assignments in always_comb with a default first, so no latch is inferred.
  always_comb begin
    starveNext = starveCnt;
    if (popHead) begin
      starveNext = '0;
    end else if (bufNonEmpty && (starveCnt != 4'(STARVE_LIMIT))) begin
      starveNext = starveCnt + 4'd1;
    end
  end

  // Saturating at the limit keeps StallReq asserted while the pipe ignores it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
      StallReq  <= 1'b0;
    end else begin
      starveCnt <= starveNext;
      StallReq  <= (starveNext == 4'(STARVE_LIMIT));
    end
  end
`else
  assign StallReq = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; expected RF writes go through a scoreboard
// queue. Starvation steps run only when RF_ARB_STARVE_GUARD_EN is defined.
module tb_rf_write_arbiter;
  import rv_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        PipeRegWrite;
  logic [4:0]  PipeRd;
  logic [31:0] PipeData;
  logic        LuValid;
  logic [4:0]  LuRd;
  logic [31:0] LuData;
  logic        LuReady;
  logic        StallReq;
  logic        RfWe;
  logic [4:0]  RfWaddr;
  logic [31:0] RfWdata;
  logic [1:0]  BufCount;

  int vectors = 0;
  int miscompares = 0;
  rf_wr_t sb[$];

  rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .PipeRegWrite(PipeRegWrite),
    .PipeRd      (PipeRd),
    .PipeData    (PipeData),
    .LuValid     (LuValid),
    .LuRd        (LuRd),
    .LuData      (LuData),
    .LuReady     (LuReady),
    .StallReq    (StallReq),
    .RfWe        (RfWe),
    .RfWaddr     (RfWaddr),
    .RfWdata     (RfWdata),
    .BufCount    (BufCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expectWr(input logic [4:0] rd, input logic [31:0] data);
    sb.push_back('{we: 1'b1, rd: rd, data: data});
  endtask

  // One clock; outputs are sampled 1 ns after the edge and any RF write is
  // matched against the head of the scoreboard.
  task automatic tick();
    rf_wr_t exp;
    @(posedge clk);
    #1;
    if (RfWe === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_rf_write", 32'(RfWaddr), 32'hFFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        chk("rf_waddr", 32'(RfWaddr), 32'(exp.rd));
        chk("rf_wdata", RfWdata, exp.data);
      end
    end
  endtask

  task automatic pipe(input logic en, input logic [4:0] rd, input logic [31:0] data);
    PipeRegWrite = en;
    PipeRd       = rd;
    PipeData     = data;
  endtask

  task automatic lu(input logic en, input logic [4:0] rd, input logic [31:0] data);
    LuValid = en;
    LuRd    = rd;
    LuData  = data;
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b1, 5'd3, 32'h3333_0000);

    // Reset held two cycles with LuValid asserted.
    tick();
    tick();
    chk("rst_rfwe", 32'(RfWe), 32'd0);
    chk("rst_waddr", 32'(RfWaddr), 32'd0);
    chk("rst_wdata", RfWdata, 32'd0);
    chk("rst_stall", 32'(StallReq), 32'd0);
    chk("rst_bufcount", 32'(BufCount), 32'd0);
    chk("rst_luready", 32'(LuReady), 32'd0);
    rst = 1'b0;
    lu(1'b0, 5'd0, 32'h0);
    #1;
    chk("post_rst_luready", 32'(LuReady), 32'd1);
    tick();
    chk("post_rst_bufcount", 32'(BufCount), 32'd0);

    // Pipe only, then a write to x0 that must be ignored.
    pipe(1'b1, 5'd1, 32'hDEAD_BEEF);
    expectWr(5'd1, 32'hDEAD_BEEF);
    tick();
    chk("pipe_rfwe", 32'(RfWe), 32'd1);
    pipe(1'b1, 5'd0, 32'h1234_5678);
    tick();
    chk("pipe_x0_rfwe", 32'(RfWe), 32'd0);
    pipe(1'b0, 5'd0, 32'h0);

    // LU drain with an idle pipe: push at n, write at n+2.
    lu(1'b1, 5'd2, 32'hCAFE_BABE);
    tick();
    chk("lu_n1_rfwe", 32'(RfWe), 32'd0);
    chk("lu_n1_bufcount", 32'(BufCount), 32'd1);
    lu(1'b0, 5'd0, 32'h0);
    expectWr(5'd2, 32'hCAFE_BABE);
    tick();
    chk("lu_n2_rfwe", 32'(RfWe), 32'd1);
    chk("lu_n2_bufcount", 32'(BufCount), 32'd0);

    // Full buffer under sustained pipe traffic.
    pipe(1'b1, 5'd10, 32'hA000_0001);
    lu(1'b1, 5'd3, 32'h3333_3333);
    expectWr(5'd10, 32'hA000_0001);
    tick();
    chk("full_cnt1", 32'(BufCount), 32'd1);
    pipe(1'b1, 5'd11, 32'hA000_0002);
    lu(1'b1, 5'd4, 32'h4444_4444);
    expectWr(5'd11, 32'hA000_0002);
    tick();
    chk("full_cnt2", 32'(BufCount), 32'd2);
    chk("full_luready", 32'(LuReady), 32'd0);
    pipe(1'b1, 5'd12, 32'hA000_0003);
    lu(1'b1, 5'd6, 32'h6666_6666);
    expectWr(5'd12, 32'hA000_0003);
    tick();
    chk("full_held_cnt", 32'(BufCount), 32'd2);
    chk("full_held_luready", 32'(LuReady), 32'd0);
    pipe(1'b0, 5'd0, 32'h0);
    expectWr(5'd3, 32'h3333_3333);
    tick();
    chk("drain1_rfwe", 32'(RfWe), 32'd1);
    chk("drain1_cnt", 32'(BufCount), 32'd1);
    chk("drain1_luready", 32'(LuReady), 32'd1);
    expectWr(5'd4, 32'h4444_4444);
    tick();
    chk("drain2_cnt", 32'(BufCount), 32'd1);
    lu(1'b0, 5'd0, 32'h0);
    expectWr(5'd6, 32'h6666_6666);
    tick();
    chk("drain3_rfwe", 32'(RfWe), 32'd1);
    chk("drain3_cnt", 32'(BufCount), 32'd0);

    // Kill of a buffered entry by a later pipe write to the same rd.
    pipe(1'b1, 5'd7, 32'h7777_7777);
    lu(1'b1, 5'd5, 32'h5555_AAAA);
    expectWr(5'd7, 32'h7777_7777);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd5, 32'h1111_1111);
    expectWr(5'd5, 32'h1111_1111);
    tick();
    chk("kill_cnt", 32'(BufCount), 32'd1);
    pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk("kill_pop_rfwe", 32'(RfWe), 32'd0);
    chk("kill_pop_cnt", 32'(BufCount), 32'd0);

    // Same-cycle push and pipe write to the same rd: stored killed.
    pipe(1'b1, 5'd9, 32'h9999_9999);
    lu(1'b1, 5'd9, 32'hDEAD_D00D);
    expectWr(5'd9, 32'h9999_9999);
    tick();
    chk("samecyc_cnt", 32'(BufCount), 32'd1);
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    tick();
    chk("samecyc_pop_rfwe", 32'(RfWe), 32'd0);
    chk("samecyc_pop_cnt", 32'(BufCount), 32'd0);

    // LuRd=0 is accepted but discarded.
    lu(1'b1, 5'd0, 32'h0BAD_0BAD);
    #1;
    chk("x0_luready", 32'(LuReady), 32'd1);
    tick();
    chk("x0_cnt", 32'(BufCount), 32'd0);
    lu(1'b0, 5'd0, 32'h0);
    tick();
    chk("x0_rfwe", 32'(RfWe), 32'd0);

    // Starvation behaviour with one buffered entry and continuous pipe writes.
    pipe(1'b1, 5'd8, 32'h8000_0000);
    lu(1'b1, 5'd13, 32'hC0C0_C0C0);
    expectWr(5'd8, 32'h8000_0000);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    chk("starve_start_stall", 32'(StallReq), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      pipe(1'b1, 5'd8, 32'h8000_0000 + 32'(k));
      expectWr(5'd8, 32'h8000_0000 + 32'(k));
      tick();
`ifdef RF_ARB_STARVE_GUARD_EN
      // Fires after four denied cycles and stays up while the pipe ignores it.
      chk($sformatf("starve_stall_%0d", k), 32'(StallReq), (k >= 4) ? 32'd1 : 32'd0);
`else
      chk($sformatf("noguard_stall_%0d", k), 32'(StallReq), 32'd0);
`endif
      chk($sformatf("starve_cnt_%0d", k), 32'(BufCount), 32'd1);
    end
    pipe(1'b0, 5'd0, 32'h0);
    expectWr(5'd13, 32'hC0C0_C0C0);
    tick();
    chk("starve_drain_rfwe", 32'(RfWe), 32'd1);
    chk("starve_drain_stall", 32'(StallReq), 32'd0);
    chk("starve_drain_cnt", 32'(BufCount), 32'd0);
    tick();
    chk("starve_after_stall", 32'(StallReq), 32'd0);

    // Reset mid-operation flushes a pending LU result.
    pipe(1'b1, 5'd14, 32'hEEEE_0001);
    lu(1'b1, 5'd15, 32'hFFFF_0001);
    expectWr(5'd14, 32'hEEEE_0001);
    tick();
    chk("midrst_pre_cnt", 32'(BufCount), 32'd1);
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    tick();
    chk("midrst_cnt", 32'(BufCount), 32'd0);
    chk("midrst_rfwe", 32'(RfWe), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_after_rfwe", 32'(RfWe), 32'd0);
    chk("midrst_after_luready", 32'(LuReady), 32'd1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
